// File: rtl/crop_pkg.sv
// crop_pkg: shared types, default widths and source-address helper
// for the crop_engine DMA slice.
package crop_pkg;

    localparam int ADDR_W_D  = 24;
    localparam int COORD_W_D = 11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    // Column-major source address, computed wide; caller truncates.
    function automatic logic [63:0] src_addr(
        input logic [31:0] x,
        input logic [31:0] y,
        input logic [31:0] c,
        input logic [31:0] h,
        input logic [31:0] ch
    );
        logic [63:0] r;
        r = {32'd0, x} * {32'd0, h} * {32'd0, ch}
          + {32'd0, y} * {32'd0, ch}
          + {32'd0, c};
        return r;
    endfunction

endpackage

// File: rtl/crop_addr_gen.sv
// crop_addr_gen: x/y/c window counters, column-major walk and last flag.
// Optional descending-x walk when CROP_MIRROR_EN is defined.
module crop_addr_gen
    import crop_pkg::*;
#(
    parameter int IMG_HEIGHT = 100,
    parameter int CHANNELS   = 3,
    parameter int ADDR_W     = ADDR_W_D,
    parameter int COORD_W    = COORD_W_D
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               init,
    input  logic               adv,
    input  logic [COORD_W-1:0] x_min,
    input  logic [COORD_W-1:0] x_max,
    input  logic [COORD_W-1:0] y_min,
    input  logic [COORD_W-1:0] y_max,
`ifdef CROP_MIRROR_EN
    input  logic               mirror,
`endif
    output logic [ADDR_W-1:0]  addr,
    output logic               last
);

    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(CHANNELS - 1);

    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [CW-1:0]      c;
    logic               mir;
    logic [COORD_W-1:0] x_end;

`ifdef CROP_MIRROR_EN
    assign mir = mirror;
`else
    assign mir = 1'b0;
`endif

    assign x_end = mir ? x_min : x_max;
    assign last  = (c == C_LAST) && (y == y_max) && (x == x_end);
    assign addr  = ADDR_W'(src_addr(32'(x), 32'(y), 32'(c),
                                    32'(IMG_HEIGHT), 32'(CHANNELS)));

    // Load window origin on init, then step c, then y, then x.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x <= '0;
            y <= '0;
            c <= '0;
        end else if (init) begin
            x <= mir ? x_max : x_min;
            y <= y_min;
            c <= '0;
        end else if (adv && !last) begin
            if (c != C_LAST) begin
                c <= c + CW'(1);
            end else begin
                c <= '0;
                if (y != y_max) begin
                    y <= y + COORD_W'(1);
                end else begin
                    y <= y_min;
                    x <= mir ? x - COORD_W'(1) : x + COORD_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/crop_engine.sv
// crop_engine: window-crop DMA, frame memory to header-offset output stream.
// Optional mirror port and reversed x walk under CROP_MIRROR_EN.
module crop_engine
    import crop_pkg::*;
#(
    parameter int IMG_WIDTH  = 100,
    parameter int IMG_HEIGHT = 100,
    parameter int CHANNELS   = 3,
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = ADDR_W_D,
    parameter int COORD_W    = COORD_W_D,
    parameter int HDR_OFFSET = 54,
    parameter int RD_LATENCY = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
`ifdef CROP_MIRROR_EN
    input  logic               mirror,
`endif
    input  logic [COORD_W-1:0] x_min,
    input  logic [COORD_W-1:0] x_max,
    input  logic [COORD_W-1:0] y_min,
    input  logic [COORD_W-1:0] y_max,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               rd_en,
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic [DATA_W-1:0]  rd_data,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [DATA_W-1:0]  wr_data,
    input  logic               wr_ready
);

    localparam int WW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [WW-1:0] W_LAST = WW'(RD_LATENCY - 1);
    localparam logic [31:0] IW = 32'(IMG_WIDTH);
    localparam logic [31:0] IH = 32'(IMG_HEIGHT);
    localparam logic [ADDR_W-1:0] HDR = ADDR_W'(HDR_OFFSET);

    state_t             state_q;
    state_t             state_d;
    logic [COORD_W-1:0] xmn_q;
    logic [COORD_W-1:0] xmx_q;
    logic [COORD_W-1:0] ymn_q;
    logic [COORD_W-1:0] ymx_q;
    logic               err_q;
    logic [ADDR_W-1:0]  wr_addr_q;
    logic [DATA_W-1:0]  wr_data_q;
    logic [WW-1:0]      wcnt_q;
    logic               start_ok;
    logic               bad;
    logic               wait_last;
    logic               acc;
    logic               last;
    logic [ADDR_W-1:0]  src;

    assign start_ok  = start && (state_q == S_IDLE || state_q == S_DONE);
    assign bad       = (xmn_q > xmx_q) || (ymn_q > ymx_q)
                    || (32'(xmx_q) >= IW) || (32'(ymx_q) >= IH);
    assign wait_last = (wcnt_q == W_LAST);
    assign acc       = (state_q == S_WRITE) && wr_ready;

`ifdef CROP_MIRROR_EN
    logic mir_q;
`endif

    crop_addr_gen #(
        .IMG_HEIGHT (IMG_HEIGHT),
        .CHANNELS   (CHANNELS),
        .ADDR_W     (ADDR_W),
        .COORD_W    (COORD_W)
    ) u_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .init   (state_q == S_CHECK),
        .adv    (acc),
        .x_min  (xmn_q),
        .x_max  (xmx_q),
        .y_min  (ymn_q),
        .y_max  (ymx_q),
`ifdef CROP_MIRROR_EN
        .mirror (mir_q),
`endif
        .addr   (src),
        .last   (last)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE,
            S_DONE:  if (start) state_d = S_CHECK;
            S_CHECK: state_d = bad ? S_DONE : S_READ;
            S_READ:  state_d = S_WAIT;
            S_WAIT:  if (wait_last) state_d = S_WRITE;
            S_WRITE: if (wr_ready) state_d = last ? S_DONE : S_READ;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state plus the datapath registers.
    always_comb begin
        busy    = !(state_q == S_IDLE || state_q == S_DONE);
        done    = (state_q == S_DONE);
        rd_en   = (state_q == S_READ);
        wr_en   = (state_q == S_WRITE);
        rd_addr = rd_en ? src : '0;
        err     = err_q;
        wr_addr = wr_addr_q;
        wr_data = wr_data_q;
    end

    // Bounds latch, error flag, read-wait timer, capture and write pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            xmn_q     <= '0;
            xmx_q     <= '0;
            ymn_q     <= '0;
            ymx_q     <= '0;
            err_q     <= 1'b0;
            wr_addr_q <= HDR;
            wr_data_q <= '0;
            wcnt_q    <= '0;
        end else begin
            if (start_ok) begin
                xmn_q     <= x_min;
                xmx_q     <= x_max;
                ymn_q     <= y_min;
                ymx_q     <= y_max;
                err_q     <= 1'b0;
                wr_addr_q <= HDR;
            end
            if (state_q == S_CHECK && bad) err_q <= 1'b1;
            if (state_q == S_READ) begin
                wcnt_q <= '0;
            end else if (state_q == S_WAIT) begin
                wcnt_q <= wcnt_q + WW'(1);
                if (wait_last) wr_data_q <= rd_data;
            end
            if (acc) wr_addr_q <= wr_addr_q + ADDR_W'(1);
        end
    end

`ifdef CROP_MIRROR_EN
    // Traversal direction is fixed for the whole crop.
    always_ff @(posedge clk) begin
        if (!rst_n)        mir_q <= 1'b0;
        else if (start_ok) mir_q <= mirror;
    end
`endif

endmodule

// File: tb/tb_crop_engine.sv
// tb_crop_engine: scoreboard bench for crop_engine, 4x4x3 image,
// one instance at RD_LATENCY=1 and one at RD_LATENCY=3.
module tb_crop_engine;

    localparam int W = 4, H = 4, CH = 3;
    localparam int DW = 16, AW = 24, CW = 11, HDR = 54;
    localparam int BUDGET = 2000;
`ifdef CROP_MIRROR_EN
    localparam bit MIR_EN = 1'b1;
`else
    localparam bit MIR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start1 = 1'b0, start3 = 1'b0;
    logic mirror = 1'b0;
    logic wr_ready = 1'b1;
    logic [CW-1:0] x_min = '0, x_max = '0, y_min = '0, y_max = '0;

    logic busy1, done1, err1, rd_en1, wr_en1;
    logic busy3, done3, err3, rd_en3, wr_en3;
    logic [AW-1:0] rd_addr1, wr_addr1, rd_addr3, wr_addr3;
    logic [DW-1:0] rd_data1, wr_data1, rd_data3, wr_data3;

    logic act = 1'b0;
    logic busy_a, done_a, err_a, rd_en_a, wr_en_a, quiet_o;
    logic [AW-1:0] rd_addr_a, wr_addr_a;
    logic [DW-1:0] wr_data_a;

    int n_chk = 0, n_fail = 0;
    int cyc = 0, nwr = 0, last_acc = -1;
    bit rate_on = 1'b0;
    bit prev_stall = 1'b0;
    logic [AW-1:0] held_a;
    logic [DW-1:0] held_d;
    int exp_rd[$], exp_wa[$], exp_wd[$];

    always #5 clk = ~clk;

    crop_engine #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .CHANNELS(CH),
        .DATA_W(DW), .ADDR_W(AW), .COORD_W(CW), .HDR_OFFSET(HDR),
        .RD_LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
`ifdef CROP_MIRROR_EN
        .mirror(mirror),
`endif
        .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
        .busy(busy1), .done(done1), .err(err1),
        .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1),
        .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
        .wr_ready(wr_ready));

    crop_engine #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .CHANNELS(CH),
        .DATA_W(DW), .ADDR_W(AW), .COORD_W(CW), .HDR_OFFSET(HDR),
        .RD_LATENCY(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3),
`ifdef CROP_MIRROR_EN
        .mirror(mirror),
`endif
        .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
        .busy(busy3), .done(done3), .err(err3),
        .rd_en(rd_en3), .rd_addr(rd_addr3), .rd_data(rd_data3),
        .wr_en(wr_en3), .wr_addr(wr_addr3), .wr_data(wr_data3),
        .wr_ready(wr_ready));

    assign busy_a    = act ? busy3 : busy1;
    assign done_a    = act ? done3 : done1;
    assign err_a     = act ? err3 : err1;
    assign rd_en_a   = act ? rd_en3 : rd_en1;
    assign wr_en_a   = act ? wr_en3 : wr_en1;
    assign rd_addr_a = act ? rd_addr3 : rd_addr1;
    assign wr_addr_a = act ? wr_addr3 : wr_addr1;
    assign wr_data_a = act ? wr_data3 : wr_data1;
    assign quiet_o   = act ? (rd_en1 | wr_en1 | busy1)
                           : (rd_en3 | wr_en3 | busy3);

    // Frame memory mem[a]=a with fixed read latency; data valid one cycle.
    logic [AW-1:0] p1;
    logic [AW-1:0] p3 [3];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        p1 <= rd_addr1;
        p3[0] <= rd_addr3;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign rd_data1 = p1[DW-1:0];
    assign rd_data3 = p3[2][DW-1:0];

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Monitor: pops expected reads/writes as the DUT presents them.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            chk("idle_dut_quiet", quiet_o, 0);
            chk("busy_done_excl", busy_a & done_a, 0);
            if (rd_en_a) begin
                if (exp_rd.size() == 0) chk("rd_extra", rd_addr_a, 0 - 1);
                else chk("rd_addr", rd_addr_a, exp_rd.pop_front());
            end
            if (prev_stall) begin
                chk("wr_hold_en", wr_en_a, 1);
                chk("wr_hold_addr", wr_addr_a, held_a);
                chk("wr_hold_data", wr_data_a, held_d);
            end
            if (wr_en_a && wr_ready) begin
                if (exp_wa.size() == 0) begin
                    chk("wr_extra", wr_addr_a, 0 - 1);
                end else begin
                    chk("wr_addr", wr_addr_a, exp_wa.pop_front());
                    chk("wr_data", wr_data_a, exp_wd.pop_front());
                end
                if (rate_on && last_acc >= 0)
                    chk("cycles_per_word", cyc - last_acc, act ? 5 : 3);
                last_acc = cyc;
                nwr++;
            end
            prev_stall = wr_en_a && !wr_ready;
            held_a = wr_addr_a;
            held_d = wr_data_a;
        end
    end

    // One crop: model the expected stream, start, drive wr_ready, check end.
    task automatic run(input bit a, input int xa, input int xb,
                       input int ya, input int yb, input bit mir,
                       input int mode);
        int n;
        int cn;
        int st;
        bit bad;
        n = 0;
        st = 0;
        act = a;
        x_min = CW'(xa);
        x_max = CW'(xb);
        y_min = CW'(ya);
        y_max = CW'(yb);
        mirror = mir;
        bad = (xa > xb) || (ya > yb) || (xb >= W) || (yb >= H);
        if (!bad) begin
            for (int i = 0; i <= xb - xa; i++)
                for (int y = ya; y <= yb; y++)
                    for (int c = 0; c < CH; c++) begin
                        int x;
                        int s;
                        x = mir ? xb - i : xa + i;
                        s = x * H * CH + y * CH + c;
                        exp_rd.push_back(s);
                        exp_wa.push_back(HDR + n);
                        exp_wd.push_back(s);
                        n++;
                    end
        end
        nwr = 0;
        last_acc = -1;
        rate_on = (mode == 0);
        wr_ready = 1'b1;
        if (a) start3 = 1'b1;
        else   start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        start3 = 1'b0;
        cn = 1;
        while (!done_a && cn < BUDGET) begin
            case (mode)
                1: wr_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (nwr == 3 && wr_en_a && st < 5) begin
                        wr_ready = 1'b0;
                        st++;
                    end else begin
                        wr_ready = 1'b1;
                    end
                end
                3: begin
                    if (nwr == 5) begin
                        wr_ready = 1'b0;
                        rst_n = 1'b0;
                        @(posedge clk); #1;
                        chk("rst_busy", busy_a, 0);
                        chk("rst_done", done_a, 0);
                        chk("rst_err", err_a, 0);
                        chk("rst_rd_en", rd_en_a, 0);
                        chk("rst_wr_en", wr_en_a, 0);
                        chk("rst_rd_addr", rd_addr_a, 0);
                        chk("rst_wr_data", wr_data_a, 0);
                        chk("rst_wr_addr", wr_addr_a, HDR);
                        @(posedge clk); #1;
                        rst_n = 1'b1;
                        wr_ready = 1'b1;
                        exp_rd.delete();
                        exp_wa.delete();
                        exp_wd.delete();
                        return;
                    end
                    wr_ready = 1'b1;
                end
                default: wr_ready = 1'b1;
            endcase
            @(posedge clk); #1;
            cn++;
        end
        wr_ready = 1'b1;
        chk("done", done_a, 1);
        chk("err", err_a, bad);
        chk("busy_end", busy_a, 0);
        if (bad) chk("err_latency_le2", cn <= 2, 1);
        chk("writes", nwr, n);
        chk("rd_left", exp_rd.size(), 0);
        chk("wr_left", exp_wa.size(), 0);
        repeat (2) @(posedge clk);
        #1;
        chk("done_held", done_a, 1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", busy1 | busy3, 0);
        chk("reset_done", done1 | done3, 0);
        chk("reset_err", err1 | err3, 0);
        chk("reset_rd_en", rd_en1 | rd_en3, 0);
        chk("reset_wr_en", wr_en1 | wr_en3, 0);
        chk("reset_wr_addr1", wr_addr1, HDR);
        chk("reset_wr_addr3", wr_addr3, HDR);
        chk("reset_wr_data", wr_data1 | wr_data3, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run(0, 1, 2, 1, 2, 0, 0);
        run(0, 3, 3, 0, 0, 0, 0);
        run(0, 2, 1, 0, 0, 0, 0);
        run(0, 0, 0, 0, 4, 0, 0);
        run(0, 1, 2, 1, 2, 0, 2);
        run(0, 1, 2, 1, 2, 0, 3);
        run(0, 1, 2, 1, 2, 0, 0);
        run(1, 1, 2, 1, 2, 0, 0);
        run(1, 1, 2, 1, 2, 0, 3);
        run(1, 1, 2, 1, 2, 0, 0);
        run(1, 0, 3, 3, 3, 0, 2);
        if (MIR_EN) begin
            run(0, 1, 2, 1, 2, 1, 0);
            run(1, 0, 3, 0, 1, 1, 1);
        end
        for (int k = 0; k < 24; k++) begin
            int xa, xb, ya, yb;
            xa = $urandom_range(0, 4);
            xb = $urandom_range(0, 4);
            ya = $urandom_range(0, 4);
            yb = $urandom_range(0, 4);
            run(1'($urandom_range(0, 1)), xa, xb, ya, yb,
                MIR_EN & 1'($urandom_range(0, 1)),
                $urandom_range(0, 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
